dmem_responder: RTL and testbench

- Memory-side responder for the data-memory request interface driven by the load/store stage: the slave end of the addr/wen/byte_en/wdata/rdata channel.
- Adds a valid/ready request handshake, a configurable number of wait states and an error response, so the core can be run against a multi-cycle data memory.
- Holds a byte-addressed storage array and returns full aligned words; the load/store stage does lane extraction and sign extension.

---
 rtl/dmem_responder.sv | 157 +++++++++++++++
 tb/tb_dmem_responder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Slave end of the data-memory request channel: valid/ready request, programmable
// wait states, byte-lane writes and whole-word little-endian reads with fault reporting.
module dmem_responder #(
  parameter int                       XLEN        = 64,
  parameter int                       DEPTH_BYTES = 1024,
  parameter int                       WAIT_CYCLES = 1,
  parameter logic [XLEN-1:0]          BASE_ADDR   = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [XLEN-1:0]             req_addr_i,
  input  logic                        req_wen_i,
  input  logic [XLEN/8-1:0]           req_byte_en_i,
  input  logic [XLEN-1:0]             req_wdata_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [XLEN-1:0]             rsp_rdata_o,
  output logic                        rsp_err_o
);

  localparam int              NB        = XLEN / 8;
  localparam int              LW        = $clog2(NB);
  localparam int              AW        = $clog2(DEPTH_BYTES);
  localparam logic [XLEN-1:0] DEPTH_X   = XLEN'(DEPTH_BYTES);
  localparam logic [3:0]      WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              ready_q;
  logic              valid_q;
  logic [XLEN-1:0]   rdata_q;
  logic              err_q;

  logic [XLEN-1:0]   addr_q;
  logic              wen_q;
  logic [NB-1:0]     be_q;
  logic [XLEN-1:0]   wdata_q;

  logic [7:0]        mem_q [DEPTH_BYTES];

  logic [XLEN-1:0]   cur_addr;
  logic              cur_wen;
  logic [NB-1:0]     cur_be;
  logic [XLEN-1:0]   cur_wdata;
  logic [XLEN-1:0]   off_w;
  logic              err_w;
  logic              accept_w;
  logic              enter_resp_w;
  logic [XLEN-1:0]   rd_word;

  assign accept_w = (state_q == S_IDLE) && req_valid_i;

  // With zero wait states the request enters RESP on its acceptance edge,
  // so the live inputs stand in for the not-yet-latched copy.
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_addr  = req_addr_i;
      cur_wen   = req_wen_i;
      cur_be    = req_byte_en_i;
      cur_wdata = req_wdata_i;
    end else begin
      cur_addr  = addr_q;
      cur_wen   = wen_q;
      cur_be    = be_q;
      cur_wdata = wdata_q;
    end
  end

  assign off_w = cur_addr - BASE_ADDR;
  assign err_w = (cur_addr[LW-1:0] != '0) || (cur_addr < BASE_ADDR) || (off_w >= DEPTH_X);

  assign enter_resp_w = (accept_w && (WAIT_CYCLES == 0)) ||
                        ((state_q == S_WAIT) && (cnt_q == 4'd0));

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NB; i++) begin
      rd_word[8*i +: 8] = mem_q[off_w[AW-1:0] + AW'(i)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            ready_q <= 1'b0;
            if (WAIT_CYCLES != 0) begin
              state_q <= S_WAIT;
              cnt_q   <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
      if (enter_resp_w) begin
        state_q <= S_RESP;
        valid_q <= 1'b1;
        err_q   <= err_w;
        rdata_q <= (err_w || cur_wen) ? '0 : rd_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept_w) begin
      addr_q  <= req_addr_i;
      wen_q   <= req_wen_i;
      be_q    <= req_byte_en_i;
      wdata_q <= req_wdata_i;
    end
  end

  // Commit shares the RESP-entry edge; a reset held at that edge drops the write.
  always_ff @(posedge clk) begin
    if (rst_n && enter_resp_w && cur_wen && !err_w) begin
      for (int i = 0; i < NB; i++) begin
        if (cur_be[i]) begin
          mem_q[off_w[AW-1:0] + AW'(i)] <= cur_wdata[8*i +: 8];
        end
      end
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three builds (1, 0 and 4 wait states) share
// the request bus; each is exercised one transaction at a time.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rsp_ready;
  logic [63:0] req_addr;
  logic        req_wen;
  logic [7:0]  req_be;
  logic [63:0] req_wdata;
  logic        vin [3];
  logic        rdy [3];
  logic        rv  [3];
  logic [63:0] rd  [3];
  logic        re  [3];

  int nchecks = 0;
  int nerrors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.XLEN(64), .DEPTH_BYTES(1024), .WAIT_CYCLES(1), .BASE_ADDR(64'h0)) u_w1 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(vin[0]), .req_ready_o(rdy[0]),
    .req_addr_i(req_addr), .req_wen_i(req_wen), .req_byte_en_i(req_be), .req_wdata_i(req_wdata),
    .rsp_valid_o(rv[0]), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rd[0]), .rsp_err_o(re[0]));

  dmem_responder #(.XLEN(64), .DEPTH_BYTES(1024), .WAIT_CYCLES(0), .BASE_ADDR(64'h0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(vin[1]), .req_ready_o(rdy[1]),
    .req_addr_i(req_addr), .req_wen_i(req_wen), .req_byte_en_i(req_be), .req_wdata_i(req_wdata),
    .rsp_valid_o(rv[1]), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rd[1]), .rsp_err_o(re[1]));

  dmem_responder #(.XLEN(64), .DEPTH_BYTES(1024), .WAIT_CYCLES(4), .BASE_ADDR(64'h0)) u_w4 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(vin[2]), .req_ready_o(rdy[2]),
    .req_addr_i(req_addr), .req_wen_i(req_wen), .req_byte_en_i(req_be), .req_wdata_i(req_wdata),
    .rsp_valid_o(rv[2]), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rd[2]), .rsp_err_o(re[2]));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Present one request, return once rsp_valid_o is seen; lat counts the
  // acceptance cycle as 1.
  task automatic issue(input int id, input logic wen, input logic [63:0] addr,
                       input logic [7:0] be, input logic [63:0] wd, output int lat);
    int k;
    chk("req_ready_before", {63'd0, rdy[id]}, 64'd1);
    req_addr  = addr;
    req_wen   = wen;
    req_be    = be;
    req_wdata = wd;
    vin[id]   = 1'b1;
    @(posedge clk); #1;
    vin[id]   = 1'b0;
    req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    k = 0;
    while (!rv[id] && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("rsp_seen", {63'd0, rv[id]}, 64'd1);
    lat = k + 1;
  endtask

  task automatic txn(input int id, input logic wen, input logic [63:0] addr,
                     input logic [7:0] be, input logic [63:0] wd,
                     output logic [63:0] data, output logic err, output int lat);
    issue(id, wen, addr, be, wd, lat);
    data = rd[id];
    err  = re[id];
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] d;
    logic        e;
    int          lat;
    rst_n = 1'b0; rsp_ready = 1'b1;
    req_addr = '0; req_wen = 1'b0; req_be = '0; req_wdata = '0;
    for (int i = 0; i < 3; i++) vin[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {63'd0, rdy[0]}, 64'd1);
    chk("rst_valid", {63'd0, rv[0]}, 64'd0);
    chk("rst_rdata", rd[0], 64'd0);
    chk("rst_err",   {63'd0, re[0]}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_valid", {63'd0, rv[0]}, 64'd0);

    txn(0, 1'b1, 64'h10, 8'hFF, 64'h1122334455667788, d, e, lat);
    chk("wr_lat_w1", 64'(lat), 64'd2);
    chk("wr_err",    {63'd0, e}, 64'd0);
    chk("wr_rdata",  d, 64'd0);
    txn(0, 1'b0, 64'h10, 8'h00, 64'h0, d, e, lat);
    chk("rd_full",   d, 64'h1122334455667788);
    chk("rd_err",    {63'd0, e}, 64'd0);

    txn(0, 1'b1, 64'h10, 8'h0F, 64'hAAAAAAAAAAAAAAAA, d, e, lat);
    txn(0, 1'b0, 64'h10, 8'h00, 64'h0, d, e, lat);
    chk("rd_partial", d, 64'h11223344AAAAAAAA);

    txn(0, 1'b1, 64'h18, 8'h00, 64'h5555555555555555, d, e, lat);
    chk("wr_be0_err", {63'd0, e}, 64'd0);
    txn(0, 1'b1, 64'h3F8, 8'hFF, 64'hCAFEF00D12345678, d, e, lat);
    txn(0, 1'b0, 64'h13, 8'h00, 64'h0, d, e, lat);
    chk("misalign_err",   {63'd0, e}, 64'd1);
    chk("misalign_rdata", d, 64'd0);
    txn(0, 1'b1, 64'h400, 8'hFF, 64'h0BAD0BAD0BAD0BAD, d, e, lat);
    chk("range_err",   {63'd0, e}, 64'd1);
    chk("range_rdata", d, 64'd0);
    txn(0, 1'b0, 64'h3F8, 8'h00, 64'h0, d, e, lat);
    chk("top_word_kept", d, 64'hCAFEF00D12345678);
    chk("top_word_err",  {63'd0, e}, 64'd0);

    rsp_ready = 1'b0;
    issue(0, 1'b0, 64'h10, 8'h00, 64'h0, lat);
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", {63'd0, rv[0]}, 64'd1);
      chk("bp_rdata", rd[0], 64'h11223344AAAAAAAA);
      chk("bp_ready", {63'd0, rdy[0]}, 64'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", {63'd0, rdy[0]}, 64'd1);
    chk("bp_release_valid", {63'd0, rv[0]}, 64'd0);

    txn(1, 1'b1, 64'h08, 8'hFF, 64'h0F0E0D0C0B0A0908, d, e, lat);
    chk("wr_lat_w0", 64'(lat), 64'd1);
    txn(1, 1'b0, 64'h08, 8'h00, 64'h0, d, e, lat);
    chk("rd_lat_w0", 64'(lat), 64'd1);
    chk("rd_w0",     d, 64'h0F0E0D0C0B0A0908);

    txn(2, 1'b1, 64'h20, 8'hFF, 64'h0123456789ABCDEF, d, e, lat);
    chk("wr_lat_w4", 64'(lat), 64'd5);
    req_addr = 64'h20; req_wen = 1'b1; req_be = 8'hFF; req_wdata = 64'hDEAD;
    vin[2] = 1'b1;
    @(posedge clk); #1;
    vin[2] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("w4_busy_ready", {63'd0, rdy[2]}, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {63'd0, rdy[2]}, 64'd1);
    chk("midrst_valid", {63'd0, rv[2]}, 64'd0);
    chk("midrst_rdata", rd[2], 64'd0);
    chk("midrst_err",   {63'd0, re[2]}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn(2, 1'b0, 64'h20, 8'h00, 64'h0, d, e, lat);
    chk("rd_lat_w4",   64'(lat), 64'd5);
    chk("write_dropped", d, 64'h0123456789ABCDEF);

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule
